// File: rtl/sad_search_ctrl.sv
// Full-search block-matching sequencer: walks every window position and tracks the accumulator's running minimum.
// Latency: first window address 2 cycles after start, done PIPE_LAT+1 cycles after the last address issue.
// Backpressure: none; one window address per cycle while scanning, and start is ignored unless idle.
module sad_search_ctrl #(
    parameter int FRAME_DIM = 64,
    parameter int BLOCK_DIM = 4,
    parameter int PIPE_LAT  = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    output logic        win_req,
    output logic [5:0]  win_row,
    output logic [5:0]  win_col,
    output logic        sad_en,
    output logic [31:0] sad_row,
    output logic [31:0] sad_col,
    output logic [31:0] min_fb,
    output logic [11:0] row_col_fb,
    input  logic [31:0] min_ret,
    input  logic [11:0] row_col_ret,
    output logic        busy,
    output logic        done,
    output logic [31:0] best_sad,
    output logic [11:0] best_row_col
);

    localparam logic [5:0] MAX_POS = 6'(FRAME_DIM - BLOCK_DIM);
    localparam int CW = $clog2(PIPE_LAT + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {IDLE, INIT, SCAN, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          dl_vld [PIPE_LAT];
    logic [5:0]    dl_row [PIPE_LAT];
    logic [5:0]    dl_col [PIPE_LAT];

    assign sad_en  = dl_vld[PIPE_LAT-1];
    assign sad_row = {26'd0, dl_row[PIPE_LAT-1]};
    assign sad_col = {26'd0, dl_col[PIPE_LAT-1]};

    // Mirrors the pixel/difference pipeline so the accumulator strobe lines up with its data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_vld[i] <= 1'b0;
                dl_row[i] <= 6'd0;
                dl_col[i] <= 6'd0;
            end
        end else begin
            dl_vld[0] <= win_req;
            dl_row[0] <= win_row;
            dl_col[0] <= win_col;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_row[i] <= dl_row[i-1];
                dl_col[i] <= dl_col[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            win_req      <= 1'b0;
            win_row      <= 6'd0;
            win_col      <= 6'd0;
            min_fb       <= 32'hFFFF_FFFF;
            row_col_fb   <= 12'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            best_sad     <= 32'd0;
            best_row_col <= 12'd0;
        end else begin
            done <= 1'b0;
            if (sad_en) begin
                min_fb     <= min_ret;
                row_col_fb <= row_col_ret;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT;
                        busy  <= 1'b1;
                    end
                end
                INIT: begin
                    min_fb     <= 32'hFFFF_FFFF;
                    row_col_fb <= 12'd0;
                    win_req    <= 1'b1;
                    win_row    <= 6'd0;
                    win_col    <= 6'd0;
                    state      <= SCAN;
                end
                SCAN: begin
                    if (win_col == MAX_POS) begin
                        win_col <= 6'd0;
                        if (win_row == MAX_POS) begin
                            win_req   <= 1'b0;
                            win_row   <= 6'd0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            win_row <= win_row + 6'd1;
                        end
                    end else begin
                        win_col <= win_col + 6'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        // The final strobe is still at the accumulator this cycle, so take its result directly.
                        best_sad     <= sad_en ? min_ret : min_fb;
                        best_row_col <= sad_en ? row_col_ret : row_col_fb;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a behavioural SAD min-accumulator and address scoreboard.
module tb_sad_search_ctrl;
    localparam int N  = 3721;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        win_req, sad_en, busy, done;
    logic [5:0]  win_row, win_col;
    logic [31:0] sad_row, sad_col, min_fb, min_ret, best_sad, sad_val;
    logic [11:0] row_col_fb, row_col_ret, best_row_col;
    int          mode;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [11:0] rc;
        int          due;
    } sad_exp_t;

    logic [11:0] exp_q [$];
    sad_exp_t    sad_q [$];

    always #5 clk = ~clk;

    sad_search_ctrl dut (
        .Clk(clk), .Reset(rst), .start(start),
        .win_req(win_req), .win_row(win_row), .win_col(win_col),
        .sad_en(sad_en), .sad_row(sad_row), .sad_col(sad_col),
        .min_fb(min_fb), .row_col_fb(row_col_fb),
        .min_ret(min_ret), .row_col_ret(row_col_ret),
        .busy(busy), .done(done), .best_sad(best_sad), .best_row_col(best_row_col)
    );

    function automatic logic [31:0] sad_of(input int m, input logic [5:0] r, input logic [5:0] c);
        case (m)
            1: return (r == 6'd12 && c == 6'd45) ? 32'd37 : 32'd1000;
            2: return ((r == 6'd3 && c == 6'd3) || (r == 6'd60 && c == 6'd60)) ? 32'd5 : 32'd1000;
            3: return 32'hFFFF_FFFF;
            default: return 32'd1000;
        endcase
    endfunction

    // External accumulator: accepts on <=, so later equal SADs take over.
    always_comb begin
        sad_val     = sad_of(mode, sad_row[5:0], sad_col[5:0]);
        min_ret     = min_fb;
        row_col_ret = row_col_fb;
        if (sad_en && sad_val <= min_fb) begin
            min_ret     = sad_val;
            row_col_ret = {sad_row[5:0], sad_col[5:0]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input int m, input logic [31:0] exp_sad, input logic [11:0] exp_rc,
                            input bit inject);
        int          issues;
        logic [11:0] e;
        sad_exp_t    s;
        issues = 0;
        mode   = m;
        exp_q.delete();
        sad_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({6'(i / 61), 6'(i % 61)});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= N + PL + 3; j++) begin
            if (j > 1) @(negedge clk);
            start = inject && (j == 100);
            chk("win_req_window", win_req, (j >= 2 && j <= N + 1));
            if (win_req) begin
                issues++;
                chk("win_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("win_addr", {win_row, win_col}, e);
                    sad_q.push_back('{e, j + PL});
                end
            end
            if (sad_en) begin
                chk("sad_pending", sad_q.size() > 0, 1);
                if (sad_q.size() > 0) begin
                    s = sad_q.pop_front();
                    chk("sad_row", sad_row, {26'd0, s.rc[11:6]});
                    chk("sad_col", sad_col, {26'd0, s.rc[5:0]});
                    chk("sad_lat", j, s.due);
                end
            end
            chk("busy", busy, (j <= N + PL + 1));
            chk("done", done, (j == N + PL + 2));
            if (done) begin
                chk("best_sad", best_sad, exp_sad);
                chk("best_row_col", best_row_col, exp_rc);
            end
        end
        chk("issue_count", issues, N);
        chk("win_q_drained", exp_q.size(), 0);
        chk("sad_q_drained", sad_q.size(), 0);
        chk("best_sad_held", best_sad, exp_sad);
        chk("best_rc_held", best_row_col, exp_rc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        chk("rst_win_req", win_req, 0);
        chk("rst_win_rc", {win_row, win_col}, 0);
        chk("rst_sad_en", sad_en, 0);
        chk("rst_sad_row", sad_row, 0);
        chk("rst_sad_col", sad_col, 0);
        chk("rst_min_fb", min_fb, 32'hFFFF_FFFF);
        chk("rst_rc_fb", row_col_fb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_best_sad", best_sad, 0);
        chk("rst_best_rc", best_row_col, 0);

        // start coincident with reset must be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("start_in_reset", busy, 0);
        @(negedge clk);
        chk("start_in_reset_2", busy, 0);

        // reset in the middle of a scan
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000 && win_row != 6'd10; k++) @(negedge clk);
        chk("reach_row10", win_row, 10);
        chk("mid_sad_en", sad_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_sad_en", sad_en, 0);
        chk("mr_min_fb", min_fb, 32'hFFFF_FFFF);
        chk("mr_win_req", win_req, 0);
        chk("mr_done", done, 0);
        chk("mr_best_sad", best_sad, 0);
        @(negedge clk);
        chk("mr_flushed", sad_en, 0);
        chk("mr_no_done", done, 0);

        run_scan(0, 32'd1000, 12'hF3C, 1'b0);
        run_scan(1, 32'd37, 12'h32D, 1'b0);
        run_scan(2, 32'd5, 12'hF3C, 1'b0);
        run_scan(3, 32'hFFFF_FFFF, 12'hF3C, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
